// File: rtl/jtcps1_pkg.sv
// Shared CPS1 video constants and types used by the scan-line buffer.
package jtcps1_pkg;

  localparam logic [8:0] LB_BLANK    = 9'h1ff;
  localparam logic [8:0] LB_HOFFSET  = 9'd64;
  localparam logic [8:0] LB_LINE_LEN = 9'd384;

  typedef enum logic [1:0] {
    LB_INIT,
    LB_IDLE,
    LB_RUN
  } lb_state_t;

endpackage

// File: rtl/jtcps1_linebuf_ram.sv
// True dual-port line RAM: independent writes on A and B, registered read on B.
module jtcps1_linebuf_ram #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic [AW:0]   addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          we_a,
  input  logic [AW:0]   addr_b,
  input  logic [DW-1:0] data_b,
  input  logic          we_b,
  output logic [DW-1:0] q_b
);

  logic [DW-1:0] mem [0:2**(AW+1)-1];

  // Port A is applied last so a writer store wins over a coincident clear.
  always_ff @(posedge clk) begin
    q_b <= mem[addr_b];
    if (we_b) mem[addr_b] <= data_b;
    if (we_a) mem[addr_a] <= data_a;
  end

endmodule

// File: rtl/jtcps1_linebuf.sv
// Double-buffered scan-line buffer: tilemap fills one bank while the other
// bank is played out, pixel by pixel, and cleared behind the read.
module jtcps1_linebuf
  import jtcps1_pkg::*;
#(
  parameter int unsigned   AW       = 9,
  parameter int unsigned   DW       = 9,
  parameter logic [DW-1:0] BLANK    = LB_BLANK,
  parameter logic [AW-1:0] HOFFSET  = LB_HOFFSET,
  parameter logic [AW-1:0] LINE_LEN = LB_LINE_LEN
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          line_start,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_data,
  input  logic          buf_wr,
  output logic [DW-1:0] pxl,
  output logic          pxl_valid,
  output logic          init_done
);

  lb_state_t     state;
  logic          wbank;
  logic [AW-1:0] h;
  logic [AW-1:0] ic;
  logic          clr_pend;
  logic [AW:0]   clr_addr;

  logic [AW-1:0] rd_col;
  logic [AW:0]   rd_addr;
  logic [AW:0]   addr_a, addr_b;
  logic [DW-1:0] data_a, data_b, q_b;
  logic          we_a, we_b;

  assign rd_col  = HOFFSET + h;
  assign rd_addr = {~wbank, rd_col};

  always_comb begin
    addr_a = {wbank, buf_addr};
    data_a = buf_data;
    we_a   = buf_wr;
    addr_b = rd_addr;
    data_b = BLANK;
    we_b   = 1'b0;
    if (state == LB_INIT) begin
      addr_a = {1'b0, ic};
      data_a = BLANK;
      we_a   = 1'b1;
      addr_b = {1'b1, ic};
      we_b   = 1'b1;
    end else if (clr_pend) begin
      addr_b = clr_addr;
      we_b   = 1'b1;
    end
  end

  jtcps1_linebuf_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk    (clk),
    .addr_a (addr_a),
    .data_a (data_a),
    .we_a   (we_a),
    .addr_b (addr_b),
    .data_b (data_b),
    .we_b   (we_b),
    .q_b    (q_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LB_INIT;
      wbank     <= 1'b0;
      h         <= '0;
      ic        <= '0;
      clr_pend  <= 1'b0;
      clr_addr  <= '0;
      pxl       <= BLANK;
      pxl_valid <= 1'b0;
      init_done <= 1'b0;
    end else begin
      clr_pend <= 1'b0;
      // A read issued last cycle lands now; the clear goes out on port B meanwhile.
      if (clr_pend) begin
        pxl       <= q_b;
        pxl_valid <= 1'b1;
      end
      case (state)
        LB_INIT: begin
          ic <= ic + 1'b1;
          if (ic == '1) begin
            state     <= LB_IDLE;
            init_done <= 1'b1;
          end
        end
        LB_IDLE, LB_RUN: begin
          if (line_start) begin
            wbank <= ~wbank;
            h     <= '0;
            state <= LB_RUN;
          end else if (state == LB_RUN && pxl_cen) begin
            if (h == LINE_LEN) begin
              pxl       <= BLANK;
              pxl_valid <= 1'b0;
              state     <= LB_IDLE;
            end else begin
              clr_pend <= 1'b1;
              clr_addr <= rd_addr;
              h        <= h + 1'b1;
            end
          end
        end
        default: state <= LB_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcps1_linebuf.sv
// Directed bench for jtcps1_linebuf: default instance plus a wrapped-offset instance.
module tb_jtcps1_linebuf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] buf_addr = '0;
  logic [8:0] buf_data = '0;
  logic       buf_wr = 1'b0;
  logic [8:0] pxl;
  logic       pxl_valid;
  logic       init_done;

  logic [8:0] w_addr = '0;
  logic [8:0] w_data = '0;
  logic       w_wr = 1'b0;
  logic [8:0] w_pxl;
  logic       w_valid;
  logic       w_done;

  logic [8:0] sp, swp;
  logic       sv, swv;

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  jtcps1_linebuf dut (
    .rst        (rst),
    .clk        (clk),
    .pxl_cen    (pxl_cen),
    .line_start (line_start),
    .buf_addr   (buf_addr),
    .buf_data   (buf_data),
    .buf_wr     (buf_wr),
    .pxl        (pxl),
    .pxl_valid  (pxl_valid),
    .init_done  (init_done)
  );

  jtcps1_linebuf #(
    .HOFFSET  (9'd400),
    .LINE_LEN (9'd200)
  ) dut_wrap (
    .rst        (rst),
    .clk        (clk),
    .pxl_cen    (pxl_cen),
    .line_start (line_start),
    .buf_addr   (w_addr),
    .buf_data   (w_data),
    .buf_wr     (w_wr),
    .pxl        (w_pxl),
    .pxl_valid  (w_valid),
    .init_done  (w_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One pixel slot of 6 clk; samples both instances just before the next slot.
  task automatic pix();
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    repeat (5) @(negedge clk);
    sp  = pxl;
    sv  = pxl_valid;
    swp = w_pxl;
    swv = w_valid;
  endtask

  task automatic pulse_ls();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [8:0] a, input logic [8:0] d);
    buf_addr = a;
    buf_data = d;
    buf_wr   = 1'b1;
    @(negedge clk);
    buf_wr   = 1'b0;
  endtask

  task automatic wr_wrap(input logic [8:0] a, input logic [8:0] d);
    w_addr = a;
    w_data = d;
    w_wr   = 1'b1;
    @(negedge clk);
    w_wr   = 1'b0;
  endtask

  initial begin
    logic [8:0] a;
    logic [8:0] e;

    // Reset and init sweep; a line_start during the sweep must be ignored.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pxl", pxl, 9'h1ff);
    chk("rst_valid", pxl_valid, 1'b0);
    chk("rst_done", init_done, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 511; i++) begin
      line_start = (i == 100);
      @(negedge clk);
    end
    line_start = 1'b0;
    chk("init_done_511", init_done, 1'b0);
    chk("init_wrap_511", w_done, 1'b0);
    @(negedge clk);
    chk("init_done_512", init_done, 1'b1);
    chk("init_wrap_512", w_done, 1'b1);
    chk("idle_valid", pxl_valid, 1'b0);

    // Freshly initialised read bank plays transparent.
    pulse_ls();
    for (int i = 0; i < 384; i++) begin
      pix();
      chk($sformatf("blank_pxl_%0d", i), sp, 9'h1ff);
      chk($sformatf("blank_vld_%0d", i), sv, 1'b1);
    end
    pix();
    chk("blank_end_vld", sv, 1'b0);
    chk("blank_end_pxl", sp, 9'h1ff);

    // Fill and play.
    for (int i = 64; i < 448; i++) begin
      a = 9'(i);
      e = a & 9'h0ff;
      wr(a, e);
    end
    pulse_ls();
    for (int i = 0; i < 384; i++) begin
      pix();
      e = 9'(64 + i) & 9'h0ff;
      chk($sformatf("fill_pxl_%0d", i), sp, e);
      chk($sformatf("fill_vld_%0d", i), sv, 1'b1);
    end
    pix();
    chk("fill_end_vld", sv, 1'b0);
    chk("fill_end_pxl", sp, 9'h1ff);

    // The bank just played must have been cleared behind the read.
    pulse_ls();
    pulse_ls();
    for (int i = 0; i < 384; i++) begin
      pix();
      chk($sformatf("clr_pxl_%0d", i), sp, 9'h1ff);
    end

    // Write coinciding with line_start lands in the pre-swap bank.
    buf_addr   = 9'd70;
    buf_data   = 9'h055;
    buf_wr     = 1'b1;
    line_start = 1'b1;
    @(negedge clk);
    buf_wr     = 1'b0;
    line_start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pix();
      chk($sformatf("coll_pxl_%0d", i), sp, (i == 6) ? 9'h055 : 9'h1ff);
    end

    // Short line: restart after 100 pixels, old bank keeps its unread pixels.
    wr(9'd164, 9'h0c3);
    wr(9'd64, 9'h011);
    pulse_ls();
    for (int i = 0; i < 100; i++) begin
      pix();
      if (i == 0)  chk("short_first", sp, 9'h011);
      if (i == 99) chk("short_99", sp, 9'h1ff);
    end
    wr(9'd64, 9'h022);
    pulse_ls();
    pix();
    chk("short_restart_pxl", sp, 9'h022);
    chk("short_restart_vld", sv, 1'b1);
    pulse_ls();
    for (int i = 0; i <= 100; i++) begin
      pix();
      if (i == 0)   chk("short_old_0", sp, 9'h1ff);
      if (i == 100) chk("short_old_164", sp, 9'h0c3);
    end

    // Wrapped address on the HOFFSET=400 / LINE_LEN=200 instance.
    wr_wrap(9'd0, 9'h0aa);
    wr_wrap(9'd511, 9'h033);
    wr_wrap(9'd400, 9'h044);
    pulse_ls();
    for (int i = 0; i <= 200; i++) begin
      pix();
      if (i == 0)   chk("wrap_p0", swp, 9'h044);
      if (i == 111) chk("wrap_p111", swp, 9'h033);
      if (i == 112) chk("wrap_p112", swp, 9'h0aa);
      if (i == 199) chk("wrap_vld_199", swv, 1'b1);
      if (i == 200) begin
        chk("wrap_end_vld", swv, 1'b0);
        chk("wrap_end_pxl", swp, 9'h1ff);
      end
    end

    // Reset mid-line restarts the sweep and wipes both banks.
    pulse_ls();
    repeat (3) pix();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_done", init_done, 1'b0);
    chk("mid_rst_vld", pxl_valid, 1'b0);
    chk("mid_rst_pxl", pxl, 9'h1ff);
    repeat (511) @(negedge clk);
    chk("reinit_511", init_done, 1'b0);
    @(negedge clk);
    chk("reinit_512", init_done, 1'b1);
    pulse_ls();
    for (int i = 0; i <= 100; i++) begin
      pix();
      if (i == 100) chk("reinit_164", sp, 9'h1ff);
    end
    pulse_ls();
    pix();
    chk("reinit_other_bank", sp, 9'h1ff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
